// File: rtl/dct_pkg.sv
// Shared types and default sizes for the DCT engine sharing arbiter.
package dct_pkg;

  localparam int unsigned BLK     = 8;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned DW_IN   = 8;
  localparam int unsigned DW_OUT  = 10;

  typedef logic [DW_IN-1:0]  pix_t;
  typedef logic [DW_OUT-1:0] coef_t;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

endpackage

// File: rtl/dct_rr_pick2.sv
// Combinational two-way round-robin pick; the pointer register is held by the parent.
module dct_rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic       o_any,
  output logic       o_owner
);

  always_comb begin
    o_any = |i_req;
    unique case (i_req)
      2'b01:   o_owner = 1'b0;
      2'b10:   o_owner = 1'b1;
      2'b11:   o_owner = i_ptr;
      default: o_owner = 1'b0;
    endcase
  end

endmodule

// File: rtl/dct_share_arb.sv
// Burst-atomic round-robin arbiter sharing one DCT engine between two requesters,
// with a watchdog that releases the engine when the owner or the DCT stalls.
module dct_share_arb
  import dct_pkg::*;
#(
  parameter int unsigned BLK     = dct_pkg::BLK,
  parameter int unsigned TIMEOUT = dct_pkg::TIMEOUT,
  parameter int unsigned DW_IN   = dct_pkg::DW_IN,
  parameter int unsigned DW_OUT  = dct_pkg::DW_OUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_in_valid0,
  input  logic              i_in_valid1,
  input  logic [DW_IN-1:0]  i_in_data0,
  input  logic [DW_IN-1:0]  i_in_data1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_dct_in_valid,
  output logic [DW_IN-1:0]  o_dct_in_data,
  input  logic              i_dct_out_valid,
  input  logic [DW_OUT-1:0] i_dct_out_data,
  output logic              o_out_valid0,
  output logic              o_out_valid1,
  output logic [DW_OUT-1:0] o_out_data0,
  output logic [DW_OUT-1:0] o_out_data1,
  output logic              o_err
);

  localparam int unsigned CW = $clog2(BLK + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LastCnt = CW'(BLK - 1);
  localparam logic [WW-1:0] LastWdg = WW'(TIMEOUT - 1);

  state_t            r_state;
  logic              r_owner;
  logic              r_rr;
  logic [CW-1:0]     r_cnt;
  logic [WW-1:0]     r_wdog;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_dct_in_valid;
  logic [DW_IN-1:0]  r_dct_in_data;
  logic              r_out_valid0;
  logic              r_out_valid1;
  logic [DW_OUT-1:0] r_out_data0;
  logic [DW_OUT-1:0] r_out_data1;
  logic              r_err;

  logic              w_any;
  logic              w_pick;
  logic              w_own_valid;
  logic [DW_IN-1:0]  w_own_data;

  dct_rr_pick2 u_pick (
    .i_req   ({i_req1, i_req0}),
    .i_ptr   (r_rr),
    .o_any   (w_any),
    .o_owner (w_pick)
  );

  assign w_own_valid = r_owner ? i_in_valid1 : i_in_valid0;
  assign w_own_data  = r_owner ? i_in_data1  : i_in_data0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_owner        <= 1'b0;
      r_rr           <= 1'b0;
      r_cnt          <= '0;
      r_wdog         <= '0;
      r_gnt0         <= 1'b0;
      r_gnt1         <= 1'b0;
      r_dct_in_valid <= 1'b0;
      r_dct_in_data  <= '0;
      r_out_valid0   <= 1'b0;
      r_out_valid1   <= 1'b0;
      r_out_data0    <= '0;
      r_out_data1    <= '0;
      r_err          <= 1'b0;
    end else begin
      r_err          <= 1'b0;
      r_dct_in_valid <= 1'b0;
      r_out_valid0   <= 1'b0;
      r_out_valid1   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // Coefficients with no burst in DRAIN are dropped and flagged.
          if (i_dct_out_valid) r_err <= 1'b1;
          if (w_any) begin
            r_owner <= w_pick;
            r_gnt0  <= ~w_pick;
            r_gnt1  <= w_pick;
            r_cnt   <= '0;
            r_wdog  <= '0;
            r_state <= FEED;
          end
        end
        FEED: begin
          if (i_dct_out_valid) r_err <= 1'b1;
          if (w_own_valid) begin
            r_dct_in_valid <= 1'b1;
            r_dct_in_data  <= w_own_data;
            r_wdog         <= '0;
            if (r_cnt == LastCnt) begin
              r_cnt   <= '0;
              r_state <= DRAIN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (r_wdog == LastWdg) begin
            r_err   <= 1'b1;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_rr    <= ~r_owner;
            r_cnt   <= '0;
            r_wdog  <= '0;
            r_state <= IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        DRAIN: begin
          if (i_dct_out_valid) begin
            if (r_owner) begin
              r_out_valid1 <= 1'b1;
              r_out_data1  <= i_dct_out_data;
            end else begin
              r_out_valid0 <= 1'b1;
              r_out_data0  <= i_dct_out_data;
            end
            r_wdog <= '0;
            if (r_cnt == LastCnt) begin
              r_cnt   <= '0;
              r_gnt0  <= 1'b0;
              r_gnt1  <= 1'b0;
              r_rr    <= ~r_owner;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (r_wdog == LastWdg) begin
            r_err   <= 1'b1;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_rr    <= ~r_owner;
            r_cnt   <= '0;
            r_wdog  <= '0;
            r_state <= IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_gnt0         = r_gnt0;
  assign o_gnt1         = r_gnt1;
  assign o_dct_in_valid = r_dct_in_valid;
  assign o_dct_in_data  = r_dct_in_data;
  assign o_out_valid0   = r_out_valid0;
  assign o_out_valid1   = r_out_valid1;
  assign o_out_data0    = r_out_data0;
  assign o_out_data1    = r_out_data1;
  assign o_err          = r_err;

endmodule

// File: tb/tb_dct_share_arb.sv
// Directed-plus-random bench for dct_share_arb; the bench plays both requesters and the DCT.
module tb_dct_share_arb;

  localparam int unsigned BLK = 8;
  localparam int unsigned TO  = 20;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic       in_valid0, in_valid1;
  logic [7:0] in_data0, in_data1;
  logic       gnt0, gnt1;
  logic       dct_in_valid;
  logic [7:0] dct_in_data;
  logic       dct_out_valid;
  logic [9:0] dct_out_data;
  logic       out_valid0, out_valid1;
  logic [9:0] out_data0, out_data1;
  logic       err;

  int         n_chk;
  int         n_pass;
  int         m_rr;
  logic [7:0] samp [BLK];

  dct_share_arb #(
    .BLK     (BLK),
    .TIMEOUT (TO),
    .DW_IN   (8),
    .DW_OUT  (10)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_req0          (req0),
    .i_req1          (req1),
    .i_in_valid0     (in_valid0),
    .i_in_valid1     (in_valid1),
    .i_in_data0      (in_data0),
    .i_in_data1      (in_data1),
    .o_gnt0          (gnt0),
    .o_gnt1          (gnt1),
    .o_dct_in_valid  (dct_in_valid),
    .o_dct_in_data   (dct_in_data),
    .i_dct_out_valid (dct_out_valid),
    .i_dct_out_data  (dct_out_data),
    .o_out_valid0    (out_valid0),
    .o_out_valid1    (out_valid1),
    .o_out_data0     (out_data0),
    .o_out_data1     (out_data1),
    .o_err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Toy transform standing in for the DCT: weighted sums of the block, 10-bit truncated.
  function automatic logic [9:0] dct_coef(input int k);
    int acc;
    acc = 0;
    for (int n = 0; n < BLK; n++) acc += int'(samp[n]) * ((((n + 1) * (k + 1)) % 7) + 1);
    return 10'(acc);
  endfunction

  task automatic set_valid(input int who, input logic v, input logic [7:0] d);
    if (who == 0) begin
      in_valid0 = v;
      in_data0  = d;
    end else begin
      in_valid1 = v;
      in_data1  = d;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {gnt0, gnt1, dct_in_valid, dct_in_data, out_valid0, out_valid1,
              out_data0, out_data1, err}, '0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    {req0, req1, in_valid0, in_valid1, dct_out_valid} = '0;
    in_data0 = '0; in_data1 = '0; dct_out_data = '0;
    tick;
    tick;
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    m_rr = 0;
  endtask

  task automatic grant_step(input logic r0, input logic r1, input string tag);
    int who;
    req0 = r0;
    req1 = r1;
    tick;
    who = (r0 && r1) ? m_rr : (r1 ? 1 : 0);
    chk({tag, "_gnt0"}, gnt0, 32'(who == 0));
    chk({tag, "_gnt1"}, gnt1, 32'(who == 1));
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic feed(input int who, input int gap, input int nsamp, input bit rnd,
                      input int base, input string tag, output int pulses);
    logic [7:0] d;
    pulses = 0;
    for (int i = 0; i < nsamp; i++) begin
      d = rnd ? 8'($urandom_range(0, 255)) : 8'(base + i);
      samp[i] = d;
      set_valid(who, 1'b1, d);
      set_valid(1 - who, 1'($urandom_range(0, 1)), 8'($urandom));
      tick;
      if (dct_in_valid) pulses++;
      chk({tag, "_in_valid"}, dct_in_valid, 1);
      chk({tag, "_in_data"}, dct_in_data, d);
      chk({tag, "_err"}, err, 0);
      set_valid(who, 1'b0, 8'h00);
      if (i < nsamp - 1) begin
        for (int g = 0; g < gap; g++) begin
          set_valid(1 - who, 1'($urandom_range(0, 1)), 8'($urandom));
          tick;
          if (dct_in_valid) pulses++;
          chk({tag, "_gap_quiet"}, dct_in_valid, 0);
          chk({tag, "_gap_err"}, err, 0);
        end
      end
    end
    set_valid(1 - who, 1'b0, 8'h00);
  endtask

  task automatic drain(input int who, input int nc, input string tag);
    logic [9:0] c;
    for (int k = 0; k < nc; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick;
        chk({tag, "_idle_ov"}, {out_valid0, out_valid1}, 0);
      end
      c = dct_coef(k);
      dct_out_valid = 1'b1;
      dct_out_data  = c;
      tick;
      dct_out_valid = 1'b0;
      chk({tag, "_ov_own"}, (who == 0) ? out_valid0 : out_valid1, 1);
      chk({tag, "_ov_other"}, (who == 0) ? out_valid1 : out_valid0, 0);
      chk({tag, "_od"}, (who == 0) ? out_data0 : out_data1, c);
      chk({tag, "_gnt"}, (who == 0) ? gnt0 : gnt1, 32'(k < BLK - 1));
      chk({tag, "_err"}, err, 0);
    end
    if (nc == BLK) m_rr = 1 - who;
  endtask

  initial begin
    int p;
    int cyc;
    bit seen;
    n_chk  = 0;
    n_pass = 0;

    // 1: req0 alone, samples 10..17.
    do_reset();
    grant_step(1'b1, 1'b0, "t1_grant");
    req0 = 1'b0;
    feed(0, 0, BLK, 1'b0, 10, "t1_feed", p);
    chk("t1_pulses", p, BLK);
    drain(0, BLK, "t1_drain");
    tick;
    chk("t1_gnt_idle", {gnt0, gnt1}, 0);

    // 2: simultaneous requests from reset, alternating service.
    do_reset();
    grant_step(1'b1, 1'b1, "t2_first");
    req0 = 1'b0;
    feed(0, 0, BLK, 1'b1, 0, "t2a_feed", p);
    drain(0, BLK, "t2a_drain");
    chk("t2_idle_gap", {gnt0, gnt1}, 0);
    grant_step(1'b0, 1'b1, "t2_second");
    feed(1, 0, BLK, 1'b1, 0, "t2b_feed", p);
    req0 = 1'b1;
    drain(1, BLK, "t2b_drain");
    grant_step(1'b1, 1'b1, "t2_third");
    req0 = 1'b0;
    req1 = 1'b0;
    feed(0, 1, BLK, 1'b1, 0, "t2c_feed", p);
    drain(0, BLK, "t2c_drain");

    // 3: three-cycle gaps between samples.
    grant_step(1'b1, 1'b0, "t3_grant");
    req0 = 1'b0;
    feed(0, 3, BLK, 1'b1, 0, "t3_feed", p);
    chk("t3_pulses", p, BLK);
    drain(0, BLK, "t3_drain");

    // 4: owner stalls after five samples while req1 waits.
    grant_step(1'b1, 1'b0, "t4_grant");
    req0 = 1'b0;
    req1 = 1'b1;
    feed(0, 0, 5, 1'b1, 0, "t4_feed", p);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < int'(TO) + 5) begin
      tick;
      cyc++;
      if (err) seen = 1'b1;
    end
    chk("t4_err_delay", cyc, TO);
    chk("t4_gnt_drop", {gnt0, gnt1}, 0);
    chk("t4_in_valid", dct_in_valid, 0);
    m_rr = 1;
    grant_step(1'b1, 1'b1, "t4_regrant");
    req0 = 1'b0;
    req1 = 1'b0;
    feed(1, 0, BLK, 1'b1, 0, "t4b_feed", p);
    drain(1, BLK, "t4b_drain");

    // 5: stray coefficient while idle.
    dct_out_valid = 1'b1;
    dct_out_data  = 10'($urandom);
    tick;
    dct_out_valid = 1'b0;
    chk("t5_err", err, 1);
    chk("t5_ov", {out_valid0, out_valid1}, 0);
    chk("t5_gnt", {gnt0, gnt1}, 0);
    tick;
    chk("t5_err_once", err, 0);
    chk("t5_still_idle", {gnt0, gnt1}, 0);

    // 6: asynchronous reset mid-DRAIN, then req1 alone.
    grant_step(1'b1, 1'b0, "t6_grant");
    req0 = 1'b0;
    feed(0, 0, BLK, 1'b1, 0, "t6_feed", p);
    drain(0, 3, "t6_drain");
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async_reset");
    tick;
    tick;
    chk_zero("t6_held_reset");
    rst_n = 1'b1;
    m_rr  = 0;
    grant_step(1'b0, 1'b1, "t6_regrant");
    req1 = 1'b0;
    feed(1, 0, BLK, 1'b1, 0, "t6b_feed", p);
    drain(1, BLK, "t6b_drain");
    tick;
    chk("t6_final_idle", {gnt0, gnt1, err}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
